// File: rtl/sbox_layer_sequencer.sv
// Streams both shares of a masked state through one shared S-box, one nibble per fresh rnd.
// Build option: define SBOX_SEQ_IDLE_ZERO_EN to drive zeros on the S-box inputs whenever no nibble is issued.
module sbox_layer_sequencer #(
  parameter int NIBBLES = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] state_s0,
  input  logic [4*NIBBLES-1:0] state_s1,
  input  logic [1:0]           rnd,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic [3:0]           sbox_in0,
  output logic [3:0]           sbox_in1,
  output logic [1:0]           sbox_guards,
  input  logic [3:0]           sbox_out0,
  input  logic [3:0]           sbox_out1,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result_s0,
  output logic [4*NIBBLES-1:0] result_s1
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                    state;
  logic [NIBBLES-1:0][3:0]   sh0, sh1, res0, res1;
  logic [CW-1:0]             issue_cnt, cap_cnt;
  logic                      in_flight;
  logic                      issue;

  // rnd_ready is high exactly in FEED, so a handshake is the only way a nibble leaves
  assign issue     = rnd_ready & rnd_valid;
  assign result_s0 = res0;
  assign result_s1 = res1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh0       <= '0;
      sh1       <= '0;
      res0      <= '0;
      res1      <= '0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      in_flight <= 1'b0;
      rnd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // The S-box answers one cycle after its inputs, so capture trails issue by one edge
      if (in_flight) begin
        res0[cap_cnt] <= sbox_out0;
        res1[cap_cnt] <= sbox_out1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            sh0       <= state_s0;
            sh1       <= state_s1;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            rnd_ready <= 1'b1;
            busy      <= 1'b1;
            state     <= FEED;
          end
        end
        FEED: begin
          in_flight <= issue;
          if (in_flight) cap_cnt <= cap_cnt + 1'b1;
          if (issue) begin
            if (issue_cnt == LAST) begin
              rnd_ready <= 1'b0;
              state     <= DRAIN;
            end else begin
              issue_cnt <= issue_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          in_flight <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SBOX_SEQ_IDLE_ZERO_EN
  always_comb begin
    sbox_in0    = 4'h0;
    sbox_in1    = 4'h0;
    sbox_guards = 2'b00;
    if (issue) begin
      sbox_in0    = sh0[issue_cnt];
      sbox_in1    = sh1[issue_cnt];
      sbox_guards = rnd;
    end
  end
`else
  logic [3:0] held0, held1;
  logic [1:0] held_g;

  // Keeps the last issued nibble on the S-box inputs during stalls and outside a run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held0  <= 4'h0;
      held1  <= 4'h0;
      held_g <= 2'b00;
    end else if (issue) begin
      held0  <= sh0[issue_cnt];
      held1  <= sh1[issue_cnt];
      held_g <= rnd;
    end
  end

  always_comb begin
    sbox_in0    = held0;
    sbox_in1    = held1;
    sbox_guards = held_g;
    if (issue) begin
      sbox_in0    = sh0[issue_cnt];
      sbox_in1    = sh1[issue_cnt];
      sbox_guards = rnd;
    end
  end
`endif

endmodule

// File: tb/tb_sbox_layer_sequencer.sv
// Bench for sbox_layer_sequencer: reference shared S-box, vector table and scoreboard of unmasked results.
module tb_sbox_layer_sequencer;
  localparam int N = 32;
  localparam int W = 4 * N;
  localparam logic [3:0] SBOX [16] = '{4'h7, 4'h4, 4'h9, 4'hc, 4'hb, 4'ha, 4'hd, 4'h8,
                                       4'hf, 4'he, 4'h1, 4'h6, 4'h0, 4'h3, 4'h2, 4'h5};

  // mode 0: rnd always valid, 1: rnd valid 50%, 2: rnd withheld for 10 cycles after start
  typedef struct {
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    int           mode;
    bit           extra;
    int           exp_cycle;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] state_s0, state_s1;
  logic [1:0]   rnd;
  logic         rnd_valid;
  logic         rnd_ready;
  logic [3:0]   sbox_in0, sbox_in1;
  logic [1:0]   sbox_guards;
  logic [3:0]   box_out0, box_out1;
  logic         busy, done;
  logic [W-1:0] result_s0, result_s1;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] cur_s0, cur_s1;
  int           issue_idx = 0;
  int           hs_cnt = 0;
  logic [3:0]   last0 = 4'h0, last1 = 4'h0;
  logic [1:0]   lastg = 2'b00;
  vec_t         vecs [6];

  always #5 clk = ~clk;

  sbox_layer_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .state_s0(state_s0), .state_s1(state_s1),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .sbox_in0(sbox_in0), .sbox_in1(sbox_in1), .sbox_guards(sbox_guards),
    .sbox_out0(box_out0), .sbox_out1(box_out1),
    .busy(busy), .done(done),
    .result_s0(result_s0), .result_s1(result_s1)
  );

  // Registered shared S-box: output shares XOR to S(in0 ^ in1), masked by the guards
  always @(posedge clk) begin
    box_out0 <= SBOX[sbox_in0 ^ sbox_in1] ^ {sbox_guards, sbox_guards};
    box_out1 <= {sbox_guards, sbox_guards};
  end

  function automatic logic [W-1:0] sbox_ref(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[4*i +: 4] = SBOX[x[4*i +: 4]];
    return r;
  endfunction

  task automatic check_output(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Every handshake must present the next nibble of both shares plus the current rnd
  always @(negedge clk) begin
    if (!rst_n) begin
      last0 = 4'h0;
      last1 = 4'h0;
      lastg = 2'b00;
    end else if (rnd_ready && rnd_valid) begin
      if (issue_idx >= N) begin
        check_output("issue_overrun", W'(issue_idx), W'(N - 1));
      end else begin
        last0 = cur_s0[4*issue_idx +: 4];
        last1 = cur_s1[4*issue_idx +: 4];
        lastg = rnd;
        check_output("sbox_in0", W'(sbox_in0), W'(last0));
        check_output("sbox_in1", W'(sbox_in1), W'(last1));
        check_output("sbox_guards", W'(sbox_guards), W'(lastg));
      end
      issue_idx++;
      hs_cnt++;
    end else begin
`ifdef SBOX_SEQ_IDLE_ZERO_EN
      check_output("idle_in0", W'(sbox_in0), W'(4'h0));
      check_output("idle_in1", W'(sbox_in1), W'(4'h0));
      check_output("idle_guards", W'(sbox_guards), W'(2'b00));
`else
      check_output("hold_in0", W'(sbox_in0), W'(last0));
      check_output("hold_in1", W'(sbox_in1), W'(last1));
      check_output("hold_guards", W'(sbox_guards), W'(lastg));
`endif
    end
  end

  task automatic apply_stimulus(input vec_t v);
    bit           seen;
    logic [W-1:0] exp_r;
    exp_r = '0;
    @(posedge clk); #1;
    start     = 1'b1;
    state_s0  = v.s0;
    state_s1  = v.s1;
    rnd_valid = 1'b0;
    cur_s0    = v.s0;
    cur_s1    = v.s1;
    issue_idx = 0;
    hs_cnt    = 0;
    exp_q.push_back(sbox_ref(v.s0 ^ v.s1));
    seen = 1'b0;
    for (int cyc = 1; cyc <= 400 && !seen; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (v.extra && (cyc == 5 || cyc == N + 2)) begin
        start    = 1'b1;
        state_s0 = ~v.s0;
        state_s1 = v.s1 ^ {4{32'h5a5a_a5a5}};
      end
      case (v.mode)
        0:       rnd_valid = 1'b1;
        1:       rnd_valid = 1'($urandom_range(0, 1));
        default: rnd_valid = (cyc > 10);
      endcase
      rnd = 2'($urandom);
      @(negedge clk);
      if (cyc == 1) check_output("busy_after_start", W'(busy), W'(1'b1));
      if (v.mode == 2 && cyc <= 10) check_output("stall_rnd_ready", W'(rnd_ready), W'(1'b1));
      if (done) begin
        seen = 1'b1;
        if (v.exp_cycle > 0) check_output("done_cycle", W'(cyc), W'(v.exp_cycle));
        exp_r = exp_q.pop_front();
        check_output("result", result_s0 ^ result_s1, exp_r);
        check_output("handshakes", W'(hs_cnt), W'(N));
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 400 cycles");
      void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    start     = 1'b0;
    rnd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_output("post_done", W'(done), W'(1'b0));
      check_output("post_busy", W'(busy), W'(1'b0));
      check_output("post_rnd_ready", W'(rnd_ready), W'(1'b0));
    end
    if (seen) check_output("result_held", result_s0 ^ result_s1, exp_r);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_busy"}, W'(busy), W'(1'b0));
    check_output({tag, "_done"}, W'(done), W'(1'b0));
    check_output({tag, "_rnd_ready"}, W'(rnd_ready), W'(1'b0));
    check_output({tag, "_sbox_in0"}, W'(sbox_in0), W'(4'h0));
    check_output({tag, "_sbox_in1"}, W'(sbox_in1), W'(4'h0));
    check_output({tag, "_guards"}, W'(sbox_guards), W'(2'b00));
    check_output({tag, "_result_s0"}, result_s0, '0);
    check_output({tag, "_result_s1"}, result_s1, '0);
  endtask

  initial begin
    int done_seen;
    vecs[0] = '{s0: '0, s1: '0, mode: 0, extra: 1'b0, exp_cycle: N + 2};
    vecs[1] = '{s0: {$urandom(), $urandom(), $urandom(), $urandom()},
                s1: {$urandom(), $urandom(), $urandom(), $urandom()}, mode: 1, extra: 1'b0, exp_cycle: 0};
    vecs[2] = '{s0: {$urandom(), $urandom(), $urandom(), $urandom()},
                s1: {$urandom(), $urandom(), $urandom(), $urandom()}, mode: 2, extra: 1'b0, exp_cycle: N + 12};
    vecs[3] = '{s0: 128'h0123456789abcdef_fedcba9876543210,
                s1: 128'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f0, mode: 0, extra: 1'b0, exp_cycle: N + 2};
    vecs[4] = '{s0: {W{1'b1}}, s1: '0, mode: 1, extra: 1'b0, exp_cycle: 0};
    vecs[5] = '{s0: {$urandom(), $urandom(), $urandom(), $urandom()},
                s1: {$urandom(), $urandom(), $urandom(), $urandom()}, mode: 0, extra: 1'b1, exp_cycle: N + 2};

    rst_n     = 1'b0;
    start     = 1'b0;
    state_s0  = '0;
    state_s1  = '0;
    rnd       = 2'b00;
    rnd_valid = 1'b0;
    cur_s0    = '0;
    cur_s1    = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

    // Abort a run at cycle 5: outputs clear at once and no done ever follows
    @(posedge clk); #1;
    start     = 1'b1;
    state_s0  = {$urandom(), $urandom(), $urandom(), $urandom()};
    state_s1  = {$urandom(), $urandom(), $urandom(), $urandom()};
    cur_s0    = state_s0;
    cur_s1    = state_s1;
    issue_idx = 0;
    hs_cnt    = 0;
    @(posedge clk); #1;
    start     = 1'b0;
    rnd_valid = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check_output("busy_before_abort", W'(busy), W'(1'b1));
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #2;
    rst_n     = 1'b1;
    rnd_valid = 1'b0;
    done_seen = 0;
    repeat (N + 5) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check_output("abort_done_pulses", W'(done_seen), W'(0));
    check_output("abort_busy", W'(busy), W'(1'b0));

    apply_stimulus(vecs[3]);
    apply_stimulus(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
